uart_rx_slave: RTL and testbench
================================

# uart_rx_slave

Bus slave that receives 8N1 UART frames on an external serial line, buffers the bytes in a small FIFO, and lets either master read them over the bit-serial ADS bus. It is the receive-side counterpart of the bus-slave UART transmitter and occupies a slave slot behind the arbiter. On the wire side it drives `ack_out`; on the bus side it follows the same serial address/data slave handshake as the other slaves.

## Interface
- `ADDR_W`, 12: serial address bits per transaction
- `DATA_W`, 8: serial data bits per transfer (UART data width)
- `CLKS_PER_BIT`, 5208: clk cycles per UART bit (50 MHz / 9600)
- `FIFO_DEPTH`, 4: RX FIFO entries, power of two, ≥2

- `clk` in 1: system clock; one clock domain
- `reset` in 1: synchronous, active-high
- `rx_in` in 1: UART serial input, idle high, asynchronous
- `validIn` in 1: arbiter qualifies `Address`/`DataIn` bit this cycle
- `wren` in 1: 1 = write, 0 = read; sampled with the first address bit
- `Address` in 1: serial address, LSB first
- `DataIn` in 1: serial write data, LSB first
- `BurstEn` in 1: ignored; every transfer is single
- `BusAvailable` in 1: arbiter ready to accept read data
- `ready` out 1: slave idle, can accept a transaction
- `validOut` out 1: `DataOut` bit valid
- `hold` out 1: read data prepared, waiting for `BusAvailable`
- `DataOut` out 1: serial read data, LSB first
- `ack_out` out 1: one-cycle pulse per byte pushed into FIFO
- `state_out` out 4: bus FSM state encoding (debug)

## Operation
- Registers, low 2 address bits decode; upper bits are ignored:
  - 0 RXDATA (R): pop oldest byte; returns 0x00 with no pop if empty
  - 1 STATUS (R): bit0 not-empty, bit1 full, bit2 overrun (sticky), bit3 frame error (sticky), bits7:4 = 0
  - 2 CTRL (W): bit0 = 1 clears sticky errors; bit1 = 1 flushes FIFO
  - 3: reads return 0x00; writes are ignored
- Receiver:
  - `rx_in` is passed through a 2-flop synchronizer.
  - A falling edge starts a frame. Wait `CLKS_PER_BIT/2`; if the line is high, abort (glitch, no error).
  - Sample 8 data bits LSB first, one every `CLKS_PER_BIT` cycles, then the stop bit.
  - Stop bit = 0: byte discarded, frame error set.
  - Stop bit = 1 and FIFO not full: push the byte and pulse `ack_out`.
  - Stop bit = 1 and FIFO full: byte dropped, overrun set, no `ack_out`.
  - Return to idle after the stop-bit sample.
- Bus FSM states (encoding in `state_out`):
  - IDLE 0, ADDR 1, WDATA 2, WCOMMIT 3, RPREP 4, RWAIT 5, RDATA 6
  - IDLE: `ready` = 1. `validIn` = 1 captures address bit 0 and latches `wren`, then go to ADDR.
  - ADDR: shift one bit per cycle while `validIn` = 1; stall while `validIn` = 0. After `ADDR_W` bits, go to WDATA if write, else RPREP.
  - WDATA: shift `DATA_W` bits while `validIn` = 1, then go to WCOMMIT.
  - WCOMMIT: apply the register write (one cycle), then go to IDLE.
  - RPREP: latch the read byte into the shift register; pop if RXDATA and not empty. Go to RWAIT.
  - RWAIT: `hold` = 1 until `BusAvailable` = 1, then go to RDATA.
  - RDATA: `validOut` = 1 for `DATA_W` cycles, shifting `DataOut` LSB first. Return to IDLE.
- Simultaneous push and pop: both occur, count unchanged. A byte pushed into a full FIFO in the same cycle as a pop is accepted.
- Flush in WCOMMIT coincident with a push: flush wins and the pushed byte is lost; no overrun is flagged.
- Clear-errors coincident with a new error: the new error stays set.
- Reset mid-frame or mid-transaction: both FSMs return to idle, the FIFO is emptied, and the errors are cleared.

## Timing
- Reset values:
  - `ready` = 1
  - `validOut`, `hold`, `DataOut`, `ack_out` = 0
  - `state_out` = 0
  - FIFO empty, sticky errors 0
- All outputs are registered.
- Read latency: last address bit → RPREP +1 → RWAIT +2 → first `DataOut` bit one cycle after `BusAvailable` is seen high in RWAIT.
- Write takes effect at the end of the WCOMMIT cycle; `ready` returns the next cycle.
- `ack_out` pulses in the cycle after the stop-bit sample.
- A byte is readable via STATUS bit0 from the cycle after that.
- Frame length is 10 × `CLKS_PER_BIT` plus 2 cycles of synchronizer delay.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: the frame is 8E1. An even-parity bit is sampled after bit 7; a mismatch discards the byte and sets the frame error.
  - Undefined: 8N1, no parity sampling.
- Register map is identical in both cases.

## Structure
- `uart_pkg` holds:
  - bus FSM and RX FSM state enums
  - register offsets (RXDATA, STATUS, CTRL)
  - STATUS bit positions
- Sub-module `uart_rx_core` holds the synchronizer, baud counter, RX FSM and parity. It outputs `byte`, `byte_valid` and `frame_err` pulses.
- FIFO and bus FSM sit in `uart_rx_slave`.

## Test plan
- `CLKS_PER_BIT`=16 in all tests.
- Send 0xA5 on `rx_in`, then bus read addr 0 → `ack_out` pulses once, `DataOut` serializes 1,0,1,0,0,1,0,1, and STATUS afterwards = 0x00.
- Send 5 bytes 0x01–0x05 with no reads → STATUS = 0x07. Four reads return 0x01–0x04; a fifth read returns 0x00.
- Frame with stop bit 0 → no `ack_out`, STATUS = 0x08. Write CTRL = 0x01 → STATUS = 0x00.
- Read request with `BusAvailable` held low 10 cycles → `hold` = 1 for 10 cycles, `validOut` = 0 throughout, then data is delivered intact.
- Byte completes in the same cycle as the RPREP pop with the FIFO full → count unchanged, no overrun.
- Assert `reset` at data bit 4 of a frame → all outputs at reset values next cycle, no `ack_out`, FIFO empty.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART receive slave.
//   - bus_state_t : bus-side FSM states. The numeric encoding is visible on
//                   state_out for debug, so the values are fixed.
//   - rx_state_t  : serial receiver FSM states.
//   - REG_*       : register offsets, decoded from the low two address bits.
//   - STAT_*      : bit positions inside the STATUS register.
//   - CTRL_*      : bit positions inside the CTRL register.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [3:0] {
        BUS_IDLE    = 4'd0,
        BUS_ADDR    = 4'd1,
        BUS_WDATA   = 4'd2,
        BUS_WCOMMIT = 4'd3,
        BUS_RPREP   = 4'd4,
        BUS_RWAIT   = 4'd5,
        BUS_RDATA   = 4'd6
    } bus_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

    localparam int CTRL_CLR_ERR = 0;
    localparam int CTRL_FLUSH   = 1;

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   Serial receiver: 2-flop synchronizer, baud counter and RX FSM.
//   Frames are 8N1 by default; define UART_RX_PARITY_EN for 8E1 (an even
//   parity bit follows the last data bit, a mismatch is a frame error).
//
// Ports
//   clk, reset  : system clock, synchronous active-high reset
//   rx_in       : asynchronous serial line, idle high
//   rx_byte     : assembled byte, valid while byte_valid is high
//   byte_valid  : one-cycle pulse in the stop-bit sample cycle of a good frame
//   frame_err   : one-cycle pulse in the stop-bit sample cycle of a bad frame
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              frame_err
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_t         state_q, state_nx;
    logic              rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]  baud_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_q;
    logic              par_err;
    logic              tick;
    logic              falling;

    // Synchronizer resets to the idle (high) level so leaving reset never
    // looks like a start bit.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real flops do.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign falling = rx_prev & ~rx_sync;

    // The start bit is checked at its midpoint; from there each full bit
    // period lands in the middle of the next bit.
    assign tick = (baud_cnt == ((state_q == RX_START) ? HALF_LIM : FULL_LIM));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // NOTE: every output of this block is given a default before the case
    // statement, so no path leaves a variable unassigned and no latch forms.
    always_comb begin
        state_nx   = state_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (falling) state_nx = RX_START;
            end
            RX_START: begin
                // Line back high at mid-start: a glitch, drop it silently.
                if (tick) state_nx = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (tick && bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                    state_nx = RX_PARITY;
`else
                    state_nx = RX_STOP;
`endif
                end
            end
            RX_PARITY: begin
                if (tick) state_nx = RX_STOP;
            end
            RX_STOP: begin
                if (tick) begin
                    state_nx = RX_IDLE;
                    if (rx_sync && !par_err) byte_valid = 1'b1;
                    else                     frame_err  = 1'b1;
                end
            end
            default: state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            par_err  <= 1'b0;
        end else begin
            if (state_q == RX_IDLE || tick) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + 1'b1;

            if (state_q == RX_IDLE) begin
                bit_idx <= '0;
                par_err <= 1'b0;
            end

            // LSB arrives first, so shift in from the top.
            if (state_q == RX_DATA && tick) begin
                shift_q <= {rx_sync, shift_q[DATA_W-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end

`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            if (state_q == RX_PARITY && tick) par_err <= (^shift_q) ^ rx_sync;
`endif
        end
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/uart_rx_slave.sv
// -----------------------------------------------------------------------------
// uart_rx_slave
//   UART receive slave on the bit-serial ADS bus. Received bytes go into a
//   small FIFO that either master drains through the RXDATA register.
//   Build option: UART_RX_PARITY_EN selects 8E1 frames in uart_rx_core.
//
// Registers (low two address bits, upper bits ignored)
//   0 RXDATA (R) : pop oldest byte, 0x00 without a pop when empty
//   1 STATUS (R) : {4'b0, frame_err, overrun, full, not_empty}
//   2 CTRL   (W) : bit0 clears sticky errors, bit1 flushes the FIFO
//   3            : reads 0x00, writes ignored
//
// Ports
//   clk, reset    : system clock, synchronous active-high reset
//   rx_in         : UART serial input
//   validIn       : Address/DataIn bit qualified this cycle
//   wren          : 1 write / 0 read, sampled with the first address bit
//   Address       : serial address, LSB first
//   DataIn        : serial write data, LSB first
//   BurstEn       : unused, every transfer is single
//   BusAvailable  : arbiter ready to take read data
//   ready         : idle, can accept a transaction
//   validOut      : DataOut bit valid
//   hold          : read data prepared, waiting for BusAvailable
//   DataOut       : serial read data, LSB first
//   ack_out       : one-cycle pulse per byte pushed into the FIFO
//   state_out     : bus FSM state (debug)
// -----------------------------------------------------------------------------
module uart_rx_slave #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       validIn,
    input  logic       wren,
    input  logic       Address,
    input  logic       DataIn,
    input  logic       BurstEn,
    input  logic       BusAvailable,
    output logic       ready,
    output logic       validOut,
    output logic       hold,
    output logic       DataOut,
    output logic       ack_out,
    output logic [3:0] state_out
);
    import uart_pkg::*;

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int ACNT_W = $clog2(ADDR_W + 1);
    localparam int DCNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [ACNT_W-1:0] ADDR_LAST = ACNT_W'(ADDR_W - 1);
    localparam logic [DCNT_W-1:0] DATA_LAST = DCNT_W'(DATA_W - 1);
    localparam logic [DCNT_W-1:0] DATA_DONE = DCNT_W'(DATA_W);

    // ---------------------------------------------------------------- receiver
    logic [DATA_W-1:0] rx_byte;
    logic              byte_valid;
    logic              frame_err;

    uart_rx_core #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    logic unused_burst;
    assign unused_burst = BurstEn;

    // ---------------------------------------------------------------- bus FSM
    bus_state_t        state_q, state_nx;
    logic              wr_q;
    logic [1:0]        reg_sel;
    logic [1:0]        wbits;
    logic [ACNT_W-1:0] a_cnt;
    logic [DCNT_W-1:0] d_cnt;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] rd_val;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty, fifo_full;
    logic              push, pop, flush, clr_err, ovr_set, wr_commit;
    logic              overrun_q, frame_err_q;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FIFO_FULL);

    always_comb begin
        state_nx = state_q;
        case (state_q)
            BUS_IDLE:    if (validIn) state_nx = BUS_ADDR;
            BUS_ADDR:    if (validIn && a_cnt == ADDR_LAST)
                             state_nx = wr_q ? BUS_WDATA : BUS_RPREP;
            BUS_WDATA:   if (validIn && d_cnt == DATA_LAST) state_nx = BUS_WCOMMIT;
            BUS_WCOMMIT: state_nx = BUS_IDLE;
            BUS_RPREP:   state_nx = BUS_RWAIT;
            BUS_RWAIT:   if (BusAvailable) state_nx = BUS_RDATA;
            BUS_RDATA:   if (d_cnt == DATA_DONE) state_nx = BUS_IDLE;
            default:     state_nx = BUS_IDLE;
        endcase
    end

    // Read source, sampled into rd_sh in RPREP.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_RXDATA: if (!fifo_empty) rd_val = fifo_mem[rd_ptr];
            REG_STATUS: begin
                rd_val[STAT_NOT_EMPTY] = !fifo_empty;
                rd_val[STAT_FULL]      = fifo_full;
                rd_val[STAT_OVERRUN]   = overrun_q;
                rd_val[STAT_FRAME_ERR] = frame_err_q;
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BUS_IDLE;
            wr_q     <= 1'b0;
            reg_sel  <= '0;
            wbits    <= '0;
            a_cnt    <= '0;
            d_cnt    <= '0;
            rd_sh    <= '0;
            ready    <= 1'b1;
            hold     <= 1'b0;
            validOut <= 1'b0;
            DataOut  <= 1'b0;
        end else begin
            state_q <= state_nx;

            // Outputs are decoded from the next state so they are registered
            // yet line up with the state they describe.
            ready    <= (state_nx == BUS_IDLE);
            hold     <= (state_nx == BUS_RWAIT);
            validOut <= (state_nx == BUS_RDATA);
            DataOut  <= (state_nx == BUS_RDATA) ? rd_sh[0] : 1'b0;

            case (state_q)
                BUS_IDLE: begin
                    if (validIn) begin
                        wr_q    <= wren;
                        reg_sel <= {1'b0, Address};
                        wbits   <= '0;
                        a_cnt   <= ACNT_W'(1);
                    end
                end
                BUS_ADDR: begin
                    // Only the two low address bits decode; the rest are
                    // counted but not stored.
                    if (validIn) begin
                        if (a_cnt == ACNT_W'(1)) reg_sel[1] <= Address;
                        a_cnt <= a_cnt + 1'b1;
                    end
                    d_cnt <= '0;
                end
                BUS_WDATA: begin
                    if (validIn) begin
                        if (d_cnt == DCNT_W'(0)) wbits[0] <= DataIn;
                        if (d_cnt == DCNT_W'(1)) wbits[1] <= DataIn;
                        d_cnt <= d_cnt + 1'b1;
                    end
                end
                BUS_RPREP: rd_sh <= rd_val;
                BUS_RWAIT: begin
                    // Bit 0 leaves on this edge, so d_cnt counts bits sent.
                    if (BusAvailable) begin
                        rd_sh <= rd_sh >> 1;
                        d_cnt <= DCNT_W'(1);
                    end
                end
                BUS_RDATA: begin
                    if (d_cnt != DATA_DONE) begin
                        rd_sh <= rd_sh >> 1;
                        d_cnt <= d_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_out = state_q;

    // ---------------------------------------------------------------- FIFO control
    assign wr_commit = (state_q == BUS_WCOMMIT) && (reg_sel == REG_CTRL);
    assign flush     = wr_commit && wbits[CTRL_FLUSH];
    assign clr_err   = wr_commit && wbits[CTRL_CLR_ERR];
    assign pop       = (state_q == BUS_RPREP) && (reg_sel == REG_RXDATA) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    // A flush discards a coincident byte without calling it an overrun.
    assign push      = byte_valid && (!fifo_full || pop) && !flush;
    assign ovr_set   = byte_valid && fifo_full && !pop && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ack_out     <= 1'b0;
        end else begin
            ack_out <= push;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end

            // Set beats clear, so an error arriving with the clear survives.
            overrun_q   <= (overrun_q   & ~clr_err) | ovr_set;
            frame_err_q <= (frame_err_q & ~clr_err) | frame_err;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so clearing the data itself buys nothing.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_byte;
    end

endmodule

// File: tb/tb_uart_rx_slave.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_slave
//   Self-checking bench for uart_rx_slave with CLKS_PER_BIT = 16. A small
//   model (byte queue plus sticky flags) predicts every read; expected read
//   bytes go into a scoreboard queue when a read is issued and are compared
//   when the serial read data has been collected from DataOut.
// -----------------------------------------------------------------------------
module tb_uart_rx_slave;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic       validIn = 1'b0;
    logic       wren = 1'b0;
    logic       Address = 1'b0;
    logic       DataIn = 1'b0;
    logic       BurstEn = 1'b0;
    logic       BusAvailable = 1'b1;
    logic       ready, validOut, hold, DataOut, ack_out;
    logic [3:0] state_out;

    always #5 clk = ~clk;

    uart_rx_slave #(
        .ADDR_W       (12),
        .DATA_W       (8),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .validIn      (validIn),
        .wren         (wren),
        .Address      (Address),
        .DataIn       (DataIn),
        .BurstEn      (BurstEn),
        .BusAvailable (BusAvailable),
        .ready        (ready),
        .validOut     (validOut),
        .hold         (hold),
        .DataOut      (DataOut),
        .ack_out      (ack_out),
        .state_out    (state_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ model
    logic [7:0] m_fifo[$];
    logic       m_ovr = 1'b0;
    logic       m_fe  = 1'b0;
    int         exp_ack = 0;
    int         ack_cnt = 0;

    function automatic logic [7:0] model_read(input logic [11:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a[1:0])
            2'd0: if (m_fifo.size() != 0) v = m_fifo.pop_front();
            2'd1: v = {4'b0, m_fe, m_ovr, 1'(m_fifo.size() == DEPTH), 1'(m_fifo.size() != 0)};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------ monitors
    logic [7:0] sb[$];
    int         rd_done = 0;
    int         bitn = 0;
    logic [7:0] rsh = 8'h00;

    always @(negedge clk) begin
        if (ack_out) ack_cnt++;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (validOut) begin
            rsh = {DataOut, rsh[7:1]};
            bitn++;
            if (bitn == 8) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rdata", 32'(rsh), 32'(e));
                end
                bitn = 0;
                rd_done++;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ stimulus
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit track);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        if (track) begin
            if (!stop)                       m_fe = 1'b1;
            else if (m_fifo.size() < DEPTH) begin
                m_fifo.push_back(b);
                exp_ack++;
            end else                         m_ovr = 1'b1;
        end
    endtask

    task automatic bus_read(input logic [11:0] a, input int stall);
        int base, t, hcnt, vcnt;
        sb.push_back(model_read(a));
        base = rd_done;
        if (stall > 0) BusAvailable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            validIn = 1'b1;
            wren    = 1'b0;
            Address = a[i];
            @(negedge clk);
        end
        validIn = 1'b0;
        Address = 1'b0;
        if (stall > 0) begin
            t = 0;
            while (!hold && t < 20) begin @(negedge clk); t++; end
            hcnt = 0;
            vcnt = 0;
            for (int i = 0; i < stall; i++) begin
                if (hold)     hcnt++;
                if (validOut) vcnt++;
                if (i < stall - 1) @(negedge clk);
            end
            BusAvailable = 1'b1;
            @(negedge clk);
            check("hold_cycles", 32'(hcnt), 32'(stall));
            check("hold_validout", 32'(vcnt), 32'd0);
            check("hold_drop", 32'(hold), 32'd0);
        end
        t = 0;
        while (rd_done == base && t < 100) begin @(negedge clk); t++; end
        check("rd_complete", 32'(rd_done - base), 32'd1);
        t = 0;
        while (!ready && t < 20) begin @(negedge clk); t++; end
        check("rd_ready", 32'(ready), 32'd1);
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
        int t;
        for (int i = 0; i < 12; i++) begin
            validIn = 1'b1;
            wren    = 1'b1;
            Address = a[i];
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            DataIn = d[i];
            @(negedge clk);
        end
        validIn = 1'b0;
        wren    = 1'b0;
        DataIn  = 1'b0;
        Address = 1'b0;
        t = 0;
        while (!ready && t < 20) begin @(negedge clk); t++; end
        check("wr_ready", 32'(ready), 32'd1);
        if (a[1:0] == 2'd2) begin
            if (d[0]) begin m_ovr = 1'b0; m_fe = 1'b0; end
            if (d[1]) m_fifo.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},     32'(ready),     32'd1);
        check({tag, "_validOut"},  32'(validOut),  32'd0);
        check({tag, "_hold"},      32'(hold),      32'd0);
        check({tag, "_DataOut"},   32'(DataOut),   32'd0);
        check({tag, "_ack_out"},   32'(ack_out),   32'd0);
        check({tag, "_state_out"}, 32'(state_out), 32'd0);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Single byte 0xA5, read back, STATUS empty afterwards
        send_byte(8'hA5, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("ack_a5", 32'(ack_cnt), 32'(exp_ack));
        bus_read(12'h000, 0);
        bus_read(12'h001, 0);

        // Five bytes into a four-deep FIFO: full plus overrun
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("ack_five", 32'(ack_cnt), 32'(exp_ack));
        bus_read(12'h001, 0);
        for (int i = 0; i < 5; i++) bus_read(12'h000, 0);
        bus_read(12'hF01, 0);          // upper address bits ignored
        bus_read(12'h003, 0);
        bus_write(12'h003, 8'hFF);     // ignored
        bus_read(12'h001, 0);
        bus_write(12'h002, 8'h01);
        bus_read(12'h001, 0);

        // Bad stop bit: frame error, cleared through CTRL
        send_byte(8'h5A, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("ack_badstop", 32'(ack_cnt), 32'(exp_ack));
        bus_read(12'h001, 0);
        bus_write(12'h002, 8'h01);
        bus_read(12'h001, 0);

        // Read held off by BusAvailable for 10 cycles
        send_byte(8'h3C, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(12'h000, 10);

        // Flush
        send_byte(8'hC3, 1'b1, 1'b1);
        send_byte(8'h96, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        bus_write(12'h002, 8'h02);
        bus_read(12'h001, 0);
        bus_read(12'h000, 0);

        // Full FIFO: byte completes on the same edge as the RXDATA pop
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        fork
            send_byte(8'h15, 1'b1, 1'b1);
            begin
                repeat (142) @(negedge clk);
                bus_read(12'h000, 0);
            end
        join
        repeat (4) @(negedge clk);
        check("ack_coincident", 32'(ack_cnt), 32'(exp_ack));
        bus_read(12'h001, 0);
        for (int i = 0; i < 4; i++) bus_read(12'h000, 0);
        bus_read(12'h001, 0);

        // Reset during data bit 4 with a stored byte and a sticky error
        send_byte(8'h5A, 1'b0, 1'b1);
        send_byte(8'h77, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        fork
            send_byte(8'hFF, 1'b1, 1'b0);
            begin
                repeat (CPB * 5 + CPB / 2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check_reset_outputs("midframe");
                reset = 1'b0;
                m_fifo.delete();
                m_ovr = 1'b0;
                m_fe  = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("ack_midframe", 32'(ack_cnt), 32'(exp_ack));
        bus_read(12'h001, 0);
        bus_read(12'h000, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
